xspi_os_phy_master: RTL

Oversampled single/dual/quad/octo-SPI controller PHY: generates SCK and SCE from the local fabric clock, shifts transaction data out on SIO and samples returning data, one transaction (txnbc_i bits over 2**txnmode_i lanes) at a time. It is the initiator counterpart of the bridge's xSPI slave PHY and sits between the bridge's command sequencer and an external NOR flash or slave bridge. SPI mode 0 only: SCK idles low, data changes on falling edge, is sampled on rising edge.

---
 rtl/xspi_pkg.sv | 50 +++++
 rtl/xspi_sck_timer.sv | 47 ++++
 rtl/xspi_os_phy_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/xspi_pkg.sv
// -----------------------------------------------------------------------------
// xspi_pkg
// Encodings shared by the xSPI master and slave PHYs: lane modes, transfer
// direction and PHY state, plus small helpers for lane width and the number
// of bus cycles a transaction needs.
// -----------------------------------------------------------------------------
package xspi_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_QUAD   = 2'b10,
    MODE_OCTO   = 2'b11
  } xspi_mode_e;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } xspi_dir_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SCK_LO  = 2'b01,
    ST_SCK_HI  = 2'b10,
    ST_CS_HOLD = 2'b11
  } xspi_state_e;

  // Lanes in use for a mode (1, 2, 4 or 8).
  function automatic logic [3:0] lane_width(input xspi_mode_e mode);
    return 4'd1 << mode;
  endfunction

  // Mask selecting the active SIO lanes for a mode.
  function automatic logic [7:0] lane_mask(input xspi_mode_e mode);
    case (mode)
      MODE_SINGLE: return 8'h01;
      MODE_DUAL:   return 8'h03;
      MODE_QUAD:   return 8'h0F;
      default:     return 8'hFF;
    endcase
  endfunction

  // ceil(bc / lane_width). Bit counts up to 8 bits wide are supported.
  function automatic logic [7:0] bus_cycles(input logic [7:0] bc, input xspi_mode_e mode);
    logic [8:0] sum;
    sum = {1'b0, bc} + 9'(lane_width(mode)) - 9'd1;
    return 8'(sum >> mode);
  endfunction

endpackage

// File: rtl/xspi_sck_timer.sv
// -----------------------------------------------------------------------------
// xspi_sck_timer
// Half-period down-counter for the SCK generator. Loading captures the
// half-period (value = H-1) and starts a new count; while enabled the counter
// expires every H cycles and reloads itself automatically.
//   tclk_i      fabric clock
//   trst_i      asynchronous active-high reset
//   i_load      capture i_load_val as the half-period and restart the count
//   i_load_val  half-period minus one
//   i_restart   restart the count from the captured half-period
//   i_en        counter running
//   o_expire    combinational strobe on the last cycle of a half-period
// -----------------------------------------------------------------------------
module xspi_sck_timer #(
  parameter int W = 4
) (
  input  logic         tclk_i,
  input  logic         trst_i,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_restart,
  input  logic         i_en,
  output logic         o_expire
);

  logic [W-1:0] r_period;
  logic [W-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == '0);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge tclk_i or posedge trst_i) begin
    if (trst_i) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_period <= i_load_val;
      r_cnt    <= i_load_val;
    end else if (i_restart) begin
      r_cnt <= r_period;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? r_period : r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/xspi_os_phy_master.sv
// -----------------------------------------------------------------------------
// xspi_os_phy_master
// Oversampled single/dual/quad/octo SPI initiator PHY (SPI mode 0). Runs one
// transaction at a time: txnbc_i bits over 2**txnmode_i lanes, most
// significant word first, SCK half-period of clkdiv_i+1 fabric cycles.
//   tclk_i/trst_i      fabric clock, asynchronous active-high reset
//   sck_o/sce_o        serial clock, chip enable (active high)
//   sio_i/sio_o/sio_oe serial data in/out, output enable
//   clkdiv_i           SCK half-period minus one
//   txnstart_i         start request (ignored while txnbusy_o)
//   txnlast_i          drop SCE after this transaction
//   txnbc_i/txnmode_i  bit count, lane mode
//   txndir_i           0 read, 1 write
//   txndata_i/_o       transmit / receive data, LSB-aligned
//   txndone_o          one-cycle end-of-transaction pulse
//   txnbusy_o          transaction or CS hold in progress
// -----------------------------------------------------------------------------
module xspi_os_phy_master
  import xspi_pkg::*;
#(
  parameter int WORD_SIZE        = 32,
  parameter int CYCLE_COUNT_BITS = 6,
  parameter int CLK_DIV_BITS     = 4
) (
  input  logic                        tclk_i,
  input  logic                        trst_i,
  output logic                        sck_o,
  output logic                        sce_o,
  input  logic [7:0]                  sio_i,
  output logic [7:0]                  sio_o,
  output logic                        sio_oe,
  input  logic [CLK_DIV_BITS-1:0]     clkdiv_i,
  input  logic                        txnstart_i,
  input  logic                        txnlast_i,
  input  logic [CYCLE_COUNT_BITS-1:0] txnbc_i,
  input  logic [1:0]                  txnmode_i,
  input  logic                        txndir_i,
  input  logic [WORD_SIZE-1:0]        txndata_i,
  output logic [WORD_SIZE-1:0]        txndata_o,
  output logic                        txndone_o,
  output logic                        txnbusy_o
);

  localparam int CB = CYCLE_COUNT_BITS;

  xspi_state_e          r_state;
  xspi_mode_e           r_mode;
  xspi_dir_e            r_dir;
  logic                 r_last;
  logic                 r_zero;    // bc = 0: no SCK edges at all
  logic [CB-1:0]        r_nm1;     // bus cycles minus one
  logic [CB-1:0]        r_cyc;     // index of the word currently on the bus
  logic [WORD_SIZE-1:0] r_tx;
  logic [WORD_SIZE-1:0] r_shift;

  logic                 w_accept;
  logic                 w_run;
  logic                 w_zero_end;
  logic                 w_expire;
  xspi_mode_e           w_mode_in;
  logic [CB-1:0]        w_n_start;
  logic [CB-1:0]        w_next_idx;

  // Word k of N sits at bit (N-1-k)*w; idx is N-1-k.
  function automatic logic [7:0] word_sel(input logic [WORD_SIZE-1:0] data,
                                          input logic [CB-1:0]        idx,
                                          input xspi_mode_e           mode);
    logic [WORD_SIZE-1:0] v;
    v = data >> ((CB+3)'(idx) << mode);
    return v[7:0] & lane_mask(mode);
  endfunction

  assign w_mode_in  = xspi_mode_e'(txnmode_i);
  assign w_n_start  = CB'(bus_cycles(8'(txnbc_i), w_mode_in));
  assign w_next_idx = r_nm1 - r_cyc - CB'(1);
  assign w_accept   = (r_state == ST_IDLE) && txnstart_i;
  assign w_run      = (r_state != ST_IDLE);
  // A zero-length transaction finishes without waiting for the timer, so the
  // CS hold must start counting from that point.
  assign w_zero_end = (r_state == ST_SCK_HI) && r_zero;

  xspi_sck_timer #(.W(CLK_DIV_BITS)) u_timer (
    .tclk_i     (tclk_i),
    .trst_i     (trst_i),
    .i_load     (w_accept),
    .i_load_val (clkdiv_i),
    .i_restart  (w_zero_end),
    .i_en       (w_run),
    .o_expire   (w_expire)
  );

  // NOTE: the data and shift registers are reset too; they are plain
  // registers, and a reset value keeps txndata_o defined after reset.
  always_ff @(posedge tclk_i or posedge trst_i) begin
    if (trst_i) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_SINGLE;
      r_dir     <= DIR_READ;
      r_last    <= 1'b0;
      r_zero    <= 1'b0;
      r_nm1     <= '0;
      r_cyc     <= '0;
      r_tx      <= '0;
      r_shift   <= '0;
      sck_o     <= 1'b0;
      sce_o     <= 1'b0;
      sio_o     <= '0;
      sio_oe    <= 1'b0;
      txndata_o <= '0;
      txndone_o <= 1'b0;
      txnbusy_o <= 1'b0;
    end else begin
      txndone_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (txnstart_i) begin
            r_mode    <= w_mode_in;
            r_dir     <= xspi_dir_e'(txndir_i);
            r_last    <= txnlast_i;
            r_zero    <= (txnbc_i == '0);
            r_nm1     <= w_n_start - CB'(1);
            r_cyc     <= '0;
            r_tx      <= txndata_i;
            r_shift   <= '0;
            sck_o     <= 1'b0;
            sce_o     <= 1'b1;
            sio_oe    <= txndir_i;
            sio_o     <= (txndir_i && (txnbc_i != '0))
                         ? word_sel(txndata_i, w_n_start - CB'(1), w_mode_in) : 8'h00;
            txnbusy_o <= 1'b1;
            r_state   <= (txnbc_i == '0) ? ST_SCK_HI : ST_SCK_LO;
          end
        end

        ST_SCK_LO: begin
          if (w_expire) begin
            sck_o   <= 1'b1;
            r_shift <= (r_shift << lane_width(r_mode))
                       | WORD_SIZE'(sio_i & lane_mask(r_mode));
            r_state <= ST_SCK_HI;
          end
        end

        ST_SCK_HI: begin
          if (r_zero || w_expire) begin
            sck_o <= 1'b0;
            if (!r_zero && (r_cyc != r_nm1)) begin
              r_cyc   <= r_cyc + CB'(1);
              sio_o   <= (r_dir == DIR_WRITE) ? word_sel(r_tx, w_next_idx, r_mode) : 8'h00;
              r_state <= ST_SCK_LO;
            end else begin
              txndone_o <= 1'b1;
              if (!r_zero) txndata_o <= r_shift;
              if (r_last) begin
                r_state <= ST_CS_HOLD;
              end else begin
                // Streaming: SCE stays asserted into the next transaction.
                txnbusy_o <= 1'b0;
                r_state   <= ST_IDLE;
              end
            end
          end
        end

        ST_CS_HOLD: begin
          if (w_expire) begin
            sce_o     <= 1'b0;
            sio_o     <= '0;
            sio_oe    <= 1'b0;
            txnbusy_o <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
